demap_frame_ctrl: RTL and testbench
===================================

DEMAP_FRAME_CTRL -- requirements
Module: demap_frame_ctrl

Interface
REQ-001 Parameter ROW_LEN, default 1044, columns per row (col 0..ROW_LEN-1).
REQ-002 Parameter ROWS, default 4, rows per frame (row 0..ROWS-1).
REQ-003 Parameter MISS_LIMIT, default 3, consecutive missed FAS that declare loss of frame.
REQ-004 i_clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 i_rst  in  1  reset, asynchronous assert, active-high.
REQ-006 i_frame_data  in  8  line byte.
REQ-007 i_frame_data_valid  in  1  byte qualifier; the position advances only on valid cycles.
REQ-008 i_frame_data_fas  in  1  marks a byte claimed as row 0 col 0; ignored when valid=0.
REQ-009 o_frame_data  out  8  registered copy of the line byte.
REQ-010 o_frame_data_valid  out  1  registered valid, gated to 0 outside SYNC.
REQ-011 o_row_cnt  out  2  row of the byte on o_frame_data.
REQ-012 o_col_cnt  out  11  column of the byte on o_frame_data.
REQ-013 o_in_frame  out  1  high while in SYNC.
REQ-014 o_lof  out  1  loss-of-frame indication.

Function
REQ-015 Latency from input byte to o_frame_data/row/col is exactly 1 clock; all outputs are registered.
REQ-016 States: HUNT, PRESYNC, SYNC; the state and position counters change only on valid cycles.
REQ-017 Position counters: col increments per valid byte; col ROW_LEN-1 wraps to 0 and increments row; row ROWS-1 wraps to 0.
REQ-018 Expected start: the valid byte arriving when the counters wrap to row 0 col 0.
REQ-019 HUNT: counters held at 0; valid with fas -> PRESYNC, that byte is row 0 col 0.
REQ-020 PRESYNC: fas at the expected start -> SYNC; no fas at the expected start -> HUNT.
REQ-021 PRESYNC: fas at any other position restarts PRESYNC with that byte as row 0 col 0.
REQ-022 SYNC: fas at the expected start clears the miss counter.
REQ-023 SYNC: no fas at the expected start increments the miss counter; counters keep free-running on the old alignment.
REQ-024 SYNC: reaching MISS_LIMIT consecutive misses -> HUNT, counters reset to 0, and the miss counter clears.
REQ-025 SYNC: fas at an unexpected position is ignored for alignment.
REQ-026 o_frame_data_valid = input valid AND (state is SYNC, or the byte is the transition byte into SYNC).
REQ-027 o_frame_data always follows the input byte.
REQ-028 o_lof is set on reset and on any SYNC->HUNT transition.
REQ-029 o_lof clears on the same edge o_in_frame rises.
REQ-030 Invalid cycles hold the counters and state and drive o_frame_data_valid=0 on the next cycle.

Reset
REQ-031 Asynchronous assertion of i_rst forces HUNT, counters 0, and miss counter 0.
REQ-032 Reset values: o_frame_data=0, o_frame_data_valid=0, o_row_cnt=0, o_col_cnt=0, o_in_frame=0, o_lof=1.
REQ-033 Reset mid-frame discards the alignment; after release, re-alignment requires a new FAS plus one confirming FAS.

Configuration
REQ-034 Macro DEMAP_FRAME_STATS_EN defined: add output o_frame_cnt[15:0], incremented at each expected start in SYNC, wrapping.
REQ-035 Macro DEMAP_FRAME_STATS_EN defined: add output o_fas_err_cnt[15:0], incremented on each miss or unexpected fas in SYNC, saturating at 0xFFFF.
REQ-036 Macro DEMAP_FRAME_STATS_EN defined: add input i_stats_clr, which zeroes both counters on the next edge (clear wins over increment); all three are reset to 0 by i_rst.
REQ-037 Macro DEMAP_FRAME_STATS_EN undefined: these ports and counters are absent, and all other behaviour is identical.

Verification
REQ-038 Reset, then two frames of 4176 valid bytes with fas on byte 0 of each -> o_in_frame rises one clock after the second fas and o_lof falls on the same clock; o_frame_data_valid is first 1 for that byte with row 0 col 0.
REQ-039 In SYNC, a byte at row 2 col 1040 -> o_row_cnt=2 and o_col_cnt=1040 one clock later; the next valid byte gives row 2 col 1041.
REQ-040 In SYNC, omit fas on 2 consecutive expected starts, then restore it -> SYNC is held and the miss counter clears; omitting 3 -> HUNT, o_lof=1, o_in_frame=0.
REQ-041 PRESYNC with a stray fas at byte 500 -> alignment restarts and SYNC requires fas exactly 4176 valid bytes after byte 500.
REQ-042 Valid deasserted for 10 cycles mid-row at col 300 -> counters hold, and the next valid byte reports col 301.
REQ-043 With DEMAP_FRAME_STATS_EN: 5 good frames, 1 miss, then i_stats_clr -> o_frame_cnt=6 and o_fas_err_cnt=1 before the clear, both 0 after.

Source files
------------

// File: rtl/demap_frame_ctrl.sv
// demap_frame_ctrl: FAS-based row/column framer with HUNT/PRESYNC/SYNC alignment and loss-of-frame.
// Optional statistics counters are enabled by defining DEMAP_FRAME_STATS_EN.
module demap_frame_ctrl #(
    parameter int ROW_LEN    = 1044,
    parameter int ROWS       = 4,
    parameter int MISS_LIMIT = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_frame_data,
    input  logic        i_frame_data_valid,
    input  logic        i_frame_data_fas,
`ifdef DEMAP_FRAME_STATS_EN
    input  logic        i_stats_clr,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_fas_err_cnt,
`endif
    output logic [7:0]  o_frame_data,
    output logic        o_frame_data_valid,
    output logic [1:0]  o_row_cnt,
    output logic [10:0] o_col_cnt,
    output logic        o_in_frame,
    output logic        o_lof
);
    localparam int MW = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT + 1);

    typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_t;

    state_t        state_q, state_d;
    logic [1:0]    row_q, row_d, pos_row;
    logic [10:0]   col_q, col_d, pos_col;
    logic [MW-1:0] miss_q, miss_d;
    logic [7:0]    data_q, data_d;
    logic          dval_q, dval_d;
    logic [1:0]    orow_q, orow_d;
    logic [10:0]   ocol_q, ocol_d;
    logic          in_frame_q, in_frame_d;
    logic          lof_q, lof_d;
    logic          go_sync, start_evt, err_evt;
    logic          at_start, col_wrap;
    logic [1:0]    row_nx;
    logic [10:0]   col_nx;

    assign at_start = (row_q == 2'd0) && (col_q == 11'd0);
    assign col_wrap = col_q == 11'(ROW_LEN - 1);
    assign col_nx   = col_wrap ? 11'd0 : col_q + 11'd1;
    assign row_nx   = !col_wrap ? row_q : (row_q == 2'(ROWS - 1)) ? 2'd0 : row_q + 2'd1;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        miss_d    = miss_q;
        pos_row   = row_q;
        pos_col   = col_q;
        go_sync   = 1'b0;
        start_evt = 1'b0;
        err_evt   = 1'b0;
        if (i_frame_data_valid) begin
            row_d = row_nx;
            col_d = col_nx;
            case (state_q)
                HUNT: begin
                    // counters sit at 0 here, so the plain advance is the position after a FAS byte
                    if (i_frame_data_fas) state_d = PRESYNC;
                    else begin
                        row_d = row_q;
                        col_d = col_q;
                    end
                end
                PRESYNC: begin
                    if (at_start) begin
                        if (i_frame_data_fas) begin
                            state_d = SYNC;
                            go_sync = 1'b1;
                        end else begin
                            state_d = HUNT;
                            row_d   = 2'd0;
                            col_d   = 11'd0;
                        end
                    end else if (i_frame_data_fas) begin
                        pos_row = 2'd0;
                        pos_col = 11'd0;
                        row_d   = 2'd0;
                        col_d   = 11'd1;
                    end
                end
                SYNC: begin
                    if (at_start) begin
                        start_evt = 1'b1;
                        if (i_frame_data_fas) miss_d = '0;
                        else begin
                            err_evt = 1'b1;
                            if (miss_q == MW'(MISS_LIMIT - 1)) begin
                                state_d = HUNT;
                                row_d   = 2'd0;
                                col_d   = 11'd0;
                                miss_d  = '0;
                            end else miss_d = miss_q + 1'b1;
                        end
                    end else err_evt = i_frame_data_fas;
                end
                default: begin
                    state_d = HUNT;
                    row_d   = 2'd0;
                    col_d   = 11'd0;
                end
            endcase
        end
        data_d     = i_frame_data;
        dval_d     = i_frame_data_valid && (state_q == SYNC || go_sync);
        orow_d     = i_frame_data_valid ? pos_row : orow_q;
        ocol_d     = i_frame_data_valid ? pos_col : ocol_q;
        in_frame_d = state_d == SYNC;
        lof_d      = (state_q == SYNC && state_d == HUNT) ? 1'b1 :
                     (state_q != SYNC && state_d == SYNC) ? 1'b0 : lof_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= HUNT;
            row_q      <= 2'd0;
            col_q      <= 11'd0;
            miss_q     <= '0;
            data_q     <= 8'd0;
            dval_q     <= 1'b0;
            orow_q     <= 2'd0;
            ocol_q     <= 11'd0;
            in_frame_q <= 1'b0;
            lof_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            miss_q     <= miss_d;
            data_q     <= data_d;
            dval_q     <= dval_d;
            orow_q     <= orow_d;
            ocol_q     <= ocol_d;
            in_frame_q <= in_frame_d;
            lof_q      <= lof_d;
        end
    end

    assign o_frame_data       = data_q;
    assign o_frame_data_valid = dval_q;
    assign o_row_cnt          = orow_q;
    assign o_col_cnt          = ocol_q;
    assign o_in_frame         = in_frame_q;
    assign o_lof              = lof_q;

`ifdef DEMAP_FRAME_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d, fas_err_cnt_q, fas_err_cnt_d;

    // clear takes priority; the error count saturates rather than wraps
    always_comb begin
        frame_cnt_d   = i_stats_clr ? 16'd0 : frame_cnt_q + {15'd0, start_evt};
        fas_err_cnt_d = i_stats_clr ? 16'd0 :
                        (err_evt && fas_err_cnt_q != 16'hFFFF) ? fas_err_cnt_q + 16'd1 : fas_err_cnt_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            frame_cnt_q   <= 16'd0;
            fas_err_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            fas_err_cnt_q <= fas_err_cnt_d;
        end
    end

    assign o_frame_cnt   = frame_cnt_q;
    assign o_fas_err_cnt = fas_err_cnt_q;
`endif
endmodule

// File: tb/tb_demap_frame_ctrl.sv
// tb_demap_frame_ctrl: randomized bench comparing demap_frame_ctrl to a byte-offset reference model.
module tb_demap_frame_ctrl;
    localparam int RL = 1044;
    localparam int RW = 4;
    localparam int ML = 3;
    localparam int FL = RL * RW;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        v, fas;
    logic [7:0]  o_frame_data;
    logic        o_frame_data_valid;
    logic [1:0]  o_row_cnt;
    logic [10:0] o_col_cnt;
    logic        o_in_frame, o_lof;
`ifdef DEMAP_FRAME_STATS_EN
    logic        clr;
    logic [15:0] o_frame_cnt, o_fas_err_cnt;
`endif

    always #5 clk = ~clk;

    demap_frame_ctrl #(.ROW_LEN(RL), .ROWS(RW), .MISS_LIMIT(ML)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_frame_data       (din),
        .i_frame_data_valid (v),
        .i_frame_data_fas   (fas),
`ifdef DEMAP_FRAME_STATS_EN
        .i_stats_clr        (clr),
        .o_frame_cnt        (o_frame_cnt),
        .o_fas_err_cnt      (o_fas_err_cnt),
`endif
        .o_frame_data       (o_frame_data),
        .o_frame_data_valid (o_frame_data_valid),
        .o_row_cnt          (o_row_cnt),
        .o_col_cnt          (o_col_cnt),
        .o_in_frame         (o_in_frame),
        .o_lof              (o_lof)
    );

    // model: 0=hunt 1=presync 2=sync; m_k counts valid bytes since the alignment byte
    int   m_st, m_k, m_miss, m_frames, m_err, m_row, m_col;
    bit   m_lof, exp_dval, noisy;
    logic [7:0] exp_data;
    int   n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic mreset;
        m_st = 0; m_k = 0; m_miss = 0; m_frames = 0; m_err = 0;
        m_row = 0; m_col = 0; m_lof = 1'b1; exp_dval = 1'b0; exp_data = 8'd0;
    endtask

    task automatic step(input bit vi, input bit fi);
        int p;
        exp_dval = 1'b0;
        if (!vi) return;
        if (m_st == 0) begin
            p = 0;
            if (fi) begin m_st = 1; m_k = 1; end
        end else begin
            p = m_k % FL;
            if (m_st == 1) begin
                if (p == 0 && fi) begin m_st = 2; exp_dval = 1'b1; m_lof = 1'b0; end
                else if (p == 0) m_st = 0;
                else if (fi) begin p = 0; m_k = 0; end
            end else begin
                exp_dval = 1'b1;
                if (p == 0) begin
                    m_frames = (m_frames + 1) % 65536;
                    if (fi) m_miss = 0;
                    else begin
                        m_miss++;
                        if (m_err < 65535) m_err++;
                        if (m_miss == ML) begin m_st = 0; m_lof = 1'b1; m_miss = 0; end
                    end
                end else if (fi && m_err < 65535) m_err++;
            end
            m_k++;
        end
        m_row = p / RL;
        m_col = p % RL;
    endtask

    task automatic check_all;
        check("data", 32'(o_frame_data), 32'(exp_data));
        check("valid", 32'(o_frame_data_valid), 32'(exp_dval));
        check("row", 32'(o_row_cnt), 32'(m_row));
        check("col", 32'(o_col_cnt), 32'(m_col));
        check("in_frame", 32'(o_in_frame), 32'(m_st == 2));
        check("lof", 32'(o_lof), 32'(m_lof));
`ifdef DEMAP_FRAME_STATS_EN
        check("frame_cnt", 32'(o_frame_cnt), 32'(m_frames));
        check("fas_err_cnt", 32'(o_fas_err_cnt), 32'(m_err));
`endif
    endtask

    task automatic cyc(input bit vi, input bit fi, input bit ci);
        @(negedge clk);
        din = 8'($urandom);
        v = vi;
        fas = fi;
`ifdef DEMAP_FRAME_STATS_EN
        clr = ci;
`endif
        exp_data = din;
        step(vi, fi);
        if (ci) begin m_frames = 0; m_err = 0; end
        @(posedge clk);
        #1 check_all;
    endtask

    task automatic frame(input bit f0, input int n);
        bit stray;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(63) == 0)
                repeat ($urandom_range(10, 1)) cyc(1'b0, 1'($urandom_range(1)), 1'b0);
            stray = noisy && m_st == 2 && (m_k % FL) != 0 && $urandom_range(1999) == 0;
            cyc(1'b1, (i == 0) ? f0 : stray, noisy && $urandom_range(4999) == 0);
        end
    endtask

    initial begin
        mreset;
        rst = 1'b1; v = 1'b0; fas = 1'b0; din = 8'd0; noisy = 1'b0;
`ifdef DEMAP_FRAME_STATS_EN
        clr = 1'b0;
`endif
        #12 check_all;
        @(negedge clk) rst = 1'b0;
        frame(1'b1, FL);
        frame(1'b1, 2);
        check("sync_after_2nd_fas", 32'(o_in_frame), 32'd1);
        check("lof_clear_on_sync", 32'(o_lof), 32'd0);
        cyc(1'b1, 1'b0, 1'b1);
        frame(1'b0, FL - 3);
        repeat (5) frame(1'b1, FL);
        frame(1'b0, 10);
`ifdef DEMAP_FRAME_STATS_EN
        check("frame_cnt_6", 32'(o_frame_cnt), 32'd6);
        check("fas_err_cnt_1", 32'(o_fas_err_cnt), 32'd1);
        cyc(1'b1, 1'b0, 1'b1);
        check("frame_cnt_clr", 32'(o_frame_cnt), 32'd0);
        check("fas_err_cnt_clr", 32'(o_fas_err_cnt), 32'd0);
`else
        cyc(1'b1, 1'b0, 1'b0);
`endif
        frame(1'b0, FL - 11);
        frame(1'b0, FL);
        frame(1'b1, FL);
        check("sync_held_2miss", 32'(o_in_frame), 32'd1);
        noisy = 1'b1;
        repeat (3) frame(1'b0, FL);
        check("hunt_after_3miss", 32'(o_in_frame), 32'd0);
        check("lof_after_3miss", 32'(o_lof), 32'd1);
        noisy = 1'b0;
        frame(1'b1, 500);
        frame(1'b1, FL);
        check("presync_after_stray", 32'(o_in_frame), 32'd0);
        frame(1'b1, 1);
        check("sync_after_restart", 32'(o_in_frame), 32'd1);
        while (m_k % FL != 300) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b1, 1'b0);
        check("col_hold_gap", 32'(o_col_cnt), 32'd300);
        cyc(1'b1, 1'b0, 1'b0);
        check("col_after_gap", 32'(o_col_cnt), 32'd301);
        while (m_k % FL != 2 * RL + 1040) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("row2_col1040", 32'({o_row_cnt, o_col_cnt}), 32'({2'd2, 11'd1040}));
        cyc(1'b1, 1'b0, 1'b0);
        check("row2_col1041", 32'({o_row_cnt, o_col_cnt}), 32'({2'd2, 11'd1041}));
        @(negedge clk);
        rst = 1'b1;
        mreset;
        #1 check_all;
        @(negedge clk) rst = 1'b0;
        noisy = 1'b1;
        frame(1'b1, FL);
        frame(1'b1, 5);
        check("resync_after_reset", 32'(o_in_frame), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
